// File: rtl/mcycle_control.sv
// Multicycle controller FSM for the 8-bit datapath: byte-wise fetch, decode, execute, memory, writeback.
// Optional ADDI support is built when MCYCLE_ADDI_EN is defined.
module mcycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_AND = 3'b001,
  parameter logic [2:0] ALU_OR  = 3'b010,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       alusrca_o,
  output logic       memtoreg_o,
  output logic       iord_o,
  output logic       pcen_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic [1:0] pcsrc_o,
  output logic [1:0] alusrcb_o,
  output logic [3:0] irwrite_o,
  output logic [2:0] alucontrol_o,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SB    = 6'h28;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12
`ifdef MCYCLE_ADDI_EN
    ,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
`endif
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic       pcwrite;
  logic       branch;
  logic [2:0] functAlu;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

  // Unknown funct codes fall back to add so the R-type writeback stays harmless.
  always_comb begin
    functAlu = ALU_ADD;
    case (funct_i)
      FN_ADD:  functAlu = ALU_ADD;
      FN_SUB:  functAlu = ALU_SUB;
      FN_AND:  functAlu = ALU_AND;
      FN_OR:   functAlu = ALU_OR;
      FN_SLT:  functAlu = ALU_SLT;
      default: functAlu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d      = FETCH1;
    memread_o    = 1'b0;
    memwrite_o   = 1'b0;
    alusrca_o    = 1'b0;
    memtoreg_o   = 1'b0;
    iord_o       = 1'b0;
    regwrite_o   = 1'b0;
    regdst_o     = 1'b0;
    pcsrc_o      = 2'b00;
    alusrcb_o    = 2'b00;
    irwrite_o    = 4'b0000;
    alucontrol_o = ALU_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;

    case (state_q)
      FETCH1: begin
        memread_o = 1'b1;
        irwrite_o = 4'b0001;
        alusrcb_o = 2'b01;
        pcwrite   = 1'b1;
        state_d   = FETCH2;
      end
      FETCH2: begin
        memread_o = 1'b1;
        irwrite_o = 4'b0010;
        alusrcb_o = 2'b01;
        pcwrite   = 1'b1;
        state_d   = FETCH3;
      end
      FETCH3: begin
        memread_o = 1'b1;
        irwrite_o = 4'b0100;
        alusrcb_o = 2'b01;
        pcwrite   = 1'b1;
        state_d   = FETCH4;
      end
      FETCH4: begin
        memread_o = 1'b1;
        irwrite_o = 4'b1000;
        alusrcb_o = 2'b01;
        pcwrite   = 1'b1;
        state_d   = DECODE;
      end
      // The branch target is precomputed here while the opcode is decoded.
      DECODE: begin
        alusrcb_o = 2'b11;
        case (op_i)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
`ifdef MCYCLE_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default:      state_d = FETCH1;
        endcase
      end
      MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        if (op_i == OP_LB) begin
          state_d = LBRD;
        end else if (op_i == OP_SB) begin
          state_d = SBWR;
        end else begin
          state_d = FETCH1;
        end
      end
      LBRD: begin
        memread_o = 1'b1;
        iord_o    = 1'b1;
        state_d   = LBWR;
      end
      LBWR: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
        state_d    = FETCH1;
      end
      SBWR: begin
        memwrite_o = 1'b1;
        iord_o     = 1'b1;
        state_d    = FETCH1;
      end
      RTYPEEX: begin
        alusrca_o    = 1'b1;
        alucontrol_o = functAlu;
        state_d      = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
        state_d    = FETCH1;
      end
      BEQEX: begin
        alusrca_o    = 1'b1;
        alucontrol_o = ALU_SUB;
        branch       = 1'b1;
        pcsrc_o      = 2'b01;
        state_d      = FETCH1;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc_o = 2'b10;
        state_d = FETCH1;
      end
`ifdef MCYCLE_ADDI_EN
      ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = ADDIWR;
      end
      ADDIWR: begin
        regwrite_o = 1'b1;
        state_d    = FETCH1;
      end
`endif
      default: state_d = FETCH1;
    endcase
  end

  assign pcen_o  = pcwrite | (branch & zero_i);
  assign state_o = state_q;

endmodule

// File: tb/tb_mcycle_control.sv
// Self-checking bench for mcycle_control: instruction-level reference model, random and directed programs.
// Honours MCYCLE_ADDI_EN the same way as the design.
module tb_mcycle_control;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucontrol;
    logic [3:0] state;
  } outs_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [5:0] opI;
  logic [5:0] functI;
  logic       zeroI;

  logic       memreadO, memwriteO, alusrcaO, memtoregO, iordO, pcenO, regwriteO, regdstO;
  logic [1:0] pcsrcO, alusrcbO;
  logic [3:0] irwriteO;
  logic [2:0] alucontrolO;
  logic [3:0] stateO;

  int         asserts  = 0;
  int         failures = 0;
  logic       expValid = 1'b0;
  outs_t      expOuts;
  outs_t      actOuts;
  logic [5:0] curOp;
  int         curIdx;

  logic [3:0] trState    [0:7];
  logic       trPcen     [0:7];
  logic [2:0] trAlu      [0:7];
  logic       trRegwrite [0:7];
  logic [1:0] trPcsrc    [0:7];
  logic       trRegdst   [0:7];
  logic       trMemread  [0:7];
  logic       trMemtoreg [0:7];

  always #5 clk = ~clk;

  mcycle_control dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .op_i         (opI),
    .funct_i      (functI),
    .zero_i       (zeroI),
    .memread_o    (memreadO),
    .memwrite_o   (memwriteO),
    .alusrca_o    (alusrcaO),
    .memtoreg_o   (memtoregO),
    .iord_o       (iordO),
    .pcen_o       (pcenO),
    .regwrite_o   (regwriteO),
    .regdst_o     (regdstO),
    .pcsrc_o      (pcsrcO),
    .alusrcb_o    (alusrcbO),
    .irwrite_o    (irwriteO),
    .alucontrol_o (alucontrolO),
    .state_o      (stateO)
  );

  assign actOuts = {memreadO, memwriteO, alusrcaO, memtoregO, iordO, pcenO, regwriteO, regdstO,
                    pcsrcO, alusrcbO, irwriteO, alucontrolO, stateO};

  // Number of cycles an instruction occupies, from FETCH1 up to the return to FETCH1.
  function automatic int instrLen(input logic [5:0] op);
    case (op)
      6'h20:        return 8;
      6'h28, 6'h00: return 7;
      6'h04, 6'h02: return 6;
`ifdef MCYCLE_ADDI_EN
      6'h08:        return 7;
`endif
      default:      return 5;
    endcase
  endfunction

  function automatic logic [2:0] aluOf(input logic [5:0] funct);
    case (funct)
      6'h22:   return 3'b110;
      6'h24:   return 3'b001;
      6'h25:   return 3'b010;
      6'h2A:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for cycle idx of an instruction: four byte fetches, decode, then the op's own steps.
  function automatic outs_t model(input logic [5:0] op, input logic [5:0] funct, input logic z, input int idx);
    outs_t o;
    o = '0;
    if (idx < 4) begin
      o.memread = 1'b1;
      o.irwrite = 4'(1 << idx);
      o.alusrcb = 2'b01;
      o.pcen    = 1'b1;
      o.state   = 4'(idx);
    end else if (idx == 4) begin
      o.state   = 4'd4;
      o.alusrcb = 2'b11;
    end else if ((op == 6'h20 || op == 6'h28) && idx == 5) begin
      o.state = 4'd5; o.alusrca = 1'b1; o.alusrcb = 2'b10;
    end else if (op == 6'h20 && idx == 6) begin
      o.state = 4'd6; o.memread = 1'b1; o.iord = 1'b1;
    end else if (op == 6'h20 && idx == 7) begin
      o.state = 4'd7; o.regwrite = 1'b1; o.memtoreg = 1'b1;
    end else if (op == 6'h28 && idx == 6) begin
      o.state = 4'd8; o.memwrite = 1'b1; o.iord = 1'b1;
    end else if (op == 6'h00 && idx == 5) begin
      o.state = 4'd9; o.alusrca = 1'b1; o.alucontrol = aluOf(funct);
    end else if (op == 6'h00 && idx == 6) begin
      o.state = 4'd10; o.regwrite = 1'b1; o.regdst = 1'b1;
    end else if (op == 6'h04 && idx == 5) begin
      o.state = 4'd11; o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z;
    end else if (op == 6'h02 && idx == 5) begin
      o.state = 4'd12; o.pcen = 1'b1; o.pcsrc = 2'b10;
    end else if (op == 6'h08 && idx == 5) begin
      o.state = 4'd13; o.alusrca = 1'b1; o.alusrcb = 2'b10;
    end else if (op == 6'h08 && idx == 6) begin
      o.state = 4'd14; o.regwrite = 1'b1;
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Single compare point per cycle, well clear of the rising edge.
  always @(negedge clk) begin
    #2;
    if (expValid) begin
      checkOutput($sformatf("cycle op=%02h idx=%0d", curOp, curIdx), 32'(actOuts), 32'(expOuts));
    end
  end

  // zeroMode: 0/1 force the zero flag, 2 randomises it every cycle.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input int zeroMode, input int maxCyc);
    int n;
    n = instrLen(op);
    if (maxCyc < n) n = maxCyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      opI      = op;
      functI   = funct;
      zeroI    = (zeroMode == 2) ? 1'($urandom) : 1'(zeroMode);
      curOp    = op;
      curIdx   = i;
      expOuts  = model(op, funct, zeroI, i);
      expValid = 1'b1;
      #3;
      trState[i]    = stateO;
      trPcen[i]     = pcenO;
      trAlu[i]      = alucontrolO;
      trRegwrite[i] = regwriteO;
      trPcsrc[i]    = pcsrcO;
      trRegdst[i]   = regdstO;
      trMemread[i]  = memreadO;
      trMemtoreg[i] = memtoregO;
    end
  endtask

  initial begin
    logic [31:0] packedStates;
    logic [7:0]  mr;
    logic [5:0]  legalOps [0:5];
    logic [5:0]  functs [0:4];
    logic [5:0]  op;
    logic [5:0]  funct;
    legalOps = '{6'h20, 6'h28, 6'h00, 6'h04, 6'h02, 6'h08};
    functs   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    rstN   = 1'b0;
    opI    = 6'h00;
    functI = 6'h00;
    zeroI  = 1'b0;
    #1;
    checkOutput("reset state", 32'(stateO), 32'd0);
    checkOutput("reset irwrite", 32'(irwriteO), 32'h1);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;

    applyStimulus(6'h20, 6'h00, 2, 8);
    packedStates = '0;
    mr = '0;
    for (int i = 0; i < 8; i++) begin
      packedStates[i*4 +: 4] = trState[i];
      mr[i] = trMemread[i];
    end
    checkOutput("LB state sequence", packedStates, 32'h7654_3210);
    checkOutput("LB memread pattern", 32'(mr), 32'h4F);
    checkOutput("LB regwrite in LBWR", 32'(trRegwrite[7]), 32'd1);
    checkOutput("LB memtoreg in LBWR", 32'(trMemtoreg[7]), 32'd1);

    applyStimulus(6'h00, 6'h22, 2, 8);
    checkOutput("R SUB alucontrol", 32'(trAlu[5]), 32'h6);
    checkOutput("R SUB regdst", 32'(trRegdst[6]), 32'd1);
    checkOutput("R SUB regwrite", 32'(trRegwrite[6]), 32'd1);

    applyStimulus(6'h00, 6'h2A, 2, 8);
    checkOutput("R SLT alucontrol", 32'(trAlu[5]), 32'h7);

    applyStimulus(6'h04, 6'h00, 1, 8);
    checkOutput("BEQ taken pcen", 32'(trPcen[5]), 32'd1);
    checkOutput("BEQ taken pcsrc", 32'(trPcsrc[5]), 32'h1);
    applyStimulus(6'h04, 6'h00, 0, 8);
    checkOutput("BEQ not taken pcen", 32'(trPcen[5]), 32'd0);

    applyStimulus(6'h02, 6'h00, 2, 8);
    checkOutput("J pcen", 32'(trPcen[5]), 32'd1);
    checkOutput("J pcsrc", 32'(trPcsrc[5]), 32'h2);

    applyStimulus(6'h3F, 6'h00, 2, 8);
    checkOutput("illegal op decode state", 32'(trState[4]), 32'd4);
    checkOutput("illegal op regwrite", 32'(trRegwrite[4]), 32'd0);

    applyStimulus(6'h08, 6'h00, 2, 8);
`ifdef MCYCLE_ADDI_EN
    checkOutput("ADDI ex state", 32'(trState[5]), 32'd13);
    checkOutput("ADDI wr state", 32'(trState[6]), 32'd14);
    checkOutput("ADDI regwrite", 32'(trRegwrite[6]), 32'd1);
`else
    checkOutput("ADDI disabled decode state", 32'(trState[4]), 32'd4);
    checkOutput("ADDI disabled regwrite", 32'(trRegwrite[4]), 32'd0);
`endif

    // Asynchronous reset while sitting in DECODE must drop straight to FETCH1.
    applyStimulus(6'h20, 6'h00, 2, 5);
    #1;
    rstN     = 1'b0;
    expValid = 1'b0;
    #1;
    checkOutput("async reset state", 32'(stateO), 32'd0);
    checkOutput("async reset irwrite", 32'(irwriteO), 32'h1);
    checkOutput("async reset pcen", 32'(pcenO), 32'd1);
    checkOutput("async reset memread", 32'(memreadO), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset held state", 32'(stateO), 32'd0);
    @(posedge clk);
    #2 rstN = 1'b1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'($urandom);
      end else begin
        op = legalOps[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 3) == 0) begin
        funct = 6'($urandom);
      end else begin
        funct = functs[$urandom_range(0, 4)];
      end
      applyStimulus(op, funct, 2, 8);
    end

    @(negedge clk);
    expValid = 1'b0;
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
